// File: rtl/pulse_sync_rx.sv
// N-channel toggle-event receiver: each channel synchronises a foreign-domain toggle,
// turns every level change into one pending count, and drains counts over valid/ready.
module pulse_sync_rx #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       tgl_in,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*CNT_W-1:0] pend,
    output logic [N_CH-1:0]       ovf,
    input  logic [N_CH-1:0]       ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Handshake: one event of channel c is consumed on every rising edge where
    // out_valid[c] & out_ready[c]; out_valid is register-derived and never depends on out_ready.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
        logic             d_q;
        logic             evt;
        logic             take;
        logic             drop;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_nxt;
        logic             ovf_q;
        logic             ovf_nxt;

        assign evt  = sync_q[SYNC_STAGES-1] ^ d_q;
        assign take = out_valid[c] & out_ready[c];

        always_comb begin
            cnt_nxt = cnt_q;
            drop    = 1'b0;
            if (evt && !take) begin
                if (cnt_q == CNT_MAX) begin
                    drop = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end else if (!evt && take) begin
                cnt_nxt = cnt_q - CNT_ONE;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            ovf_nxt = ovf_q;
            if (drop) begin
                ovf_nxt = 1'b1;
            end else if (ovf_clr[c]) begin
                ovf_nxt = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
                d_q    <= 1'b0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in[c]};
                d_q    <= sync_q[SYNC_STAGES-1];
                cnt_q  <= cnt_nxt;
                ovf_q  <= ovf_nxt;
            end
        end

        assign out_valid[c]              = (cnt_q != '0);
        assign pend[c*CNT_W +: CNT_W]    = cnt_q;
        assign ovf[c]                    = ovf_q;
    end

endmodule

// File: tb/tb_pulse_sync_rx.sv
// Self-checking bench for pulse_sync_rx with the default 4 channels, 2 sync stages, 4-bit counters.
module tb_pulse_sync_rx;

    localparam int N_CH = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W = 4;

    logic                  clk;
    logic                  rst;
    logic [N_CH-1:0]       tgl_in;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready;
    logic [N_CH*CNT_W-1:0] pend;
    logic [N_CH-1:0]       ovf;
    logic [N_CH-1:0]       ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_q[$];

    pulse_sync_rx #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .tgl_in(tgl_in), .out_valid(out_valid),
        .out_ready(out_ready), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [CNT_W-1:0] pend_of(input int c);
        return pend[c*CNT_W +: CNT_W];
    endfunction

    // driver: flip the toggle of channel c and wait out the minimum spacing
    task automatic send_evt(input int c);
        tgl_in[c] = ~tgl_in[c];
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tgl_in = 4'($urandom_range(0, 15));
            tick(1);
            checks++;
            if (out_valid !== '0 || pend !== '0 || ovf !== '0) begin
                errors++;
                $display("FAIL reset_hold: valid=%b pend=%h ovf=%b required all 0", out_valid, pend, ovf);
            end
        end
        tgl_in = '0;
        rst = 1'b0;
        tick(6);
        checks++;
        if (out_valid !== '0 || pend !== '0 || ovf !== '0) begin
            errors++;
            $display("FAIL reset_release: valid=%b pend=%h ovf=%b required all 0", out_valid, pend, ovf);
        end
    endtask

    task automatic test_latency();
        tgl_in[0] = 1'b1;
        tick(2);
        checks++;
        if (pend_of(0) !== 4'd0 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: pend0=%0d valid0=%b required 0 0", pend_of(0), out_valid[0]);
        end
        tick(1);
        checks++;
        if (pend_of(0) !== 4'd1 || out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL latency_k2: pend0=%0d valid0=%b required 1 1", pend_of(0), out_valid[0]);
        end
        checks++;
        if (pend[N_CH*CNT_W-1:CNT_W] !== '0 || out_valid[N_CH-1:1] !== '0) begin
            errors++;
            $display("FAIL latency_others: pend=%h valid=%b required other channels 0", pend, out_valid);
        end
    endtask

    task automatic test_accumulate_drain();
        for (int i = 0; i < 5; i++) send_evt(1);
        checks++;
        if (pend_of(1) !== 4'd5 || out_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL accumulate: pend1=%0d valid1=%b required 5 1", pend_of(1), out_valid[1]);
        end
        out_ready[1] = 1'b1;
        for (int i = 4; i >= 0; i--) exp_q.push_back(CNT_W'(i));
        while (exp_q.size() > 0) begin
            logic [CNT_W-1:0] exp_v;
            tick(1);
            exp_v = exp_q.pop_front();
            checks++;
            if (pend_of(1) !== exp_v || out_valid[1] !== (exp_v != 0)) begin
                errors++;
                $display("FAIL drain: pend1=%0d valid1=%b required %0d %b", pend_of(1), out_valid[1], exp_v, exp_v != 0);
            end
        end
        // ready with nothing pending must not underflow
        tick(3);
        checks++;
        if (pend_of(1) !== 4'd0 || out_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL no_underflow: pend1=%0d valid1=%b required 0 0", pend_of(1), out_valid[1]);
        end
        out_ready[1] = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) send_evt(2);
        checks++;
        if (pend_of(2) !== 4'd15 || ovf[2] !== 1'b1) begin
            errors++;
            $display("FAIL overflow: pend2=%0d ovf2=%b required 15 1", pend_of(2), ovf[2]);
        end
        ovf_clr[2] = 1'b1;
        tick(1);
        ovf_clr[2] = 1'b0;
        tick(1);
        checks++;
        if (pend_of(2) !== 4'd15 || ovf[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: pend2=%0d ovf2=%b required 15 0", pend_of(2), ovf[2]);
        end
    endtask

    // Event arriving on the same edge as an accept: toggle, then raise ready on the third edge.
    task automatic evt_with_take(input int c);
        tgl_in[c] = ~tgl_in[c];
        tick(2);
        out_ready[c] = 1'b1;
        tick(1);
        out_ready[c] = 1'b0;
        tick(2);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 15; i++) send_evt(3);
        checks++;
        if (pend_of(3) !== 4'd15) begin
            errors++;
            $display("FAIL fill_ch3: pend3=%0d required 15", pend_of(3));
        end
        evt_with_take(3);
        checks++;
        if (pend_of(3) !== 4'd15 || ovf[3] !== 1'b0) begin
            errors++;
            $display("FAIL simul_full: pend3=%0d ovf3=%b required 15 0", pend_of(3), ovf[3]);
        end
        out_ready[3] = 1'b1;
        tick(14);
        out_ready[3] = 1'b0;
        checks++;
        if (pend_of(3) !== 4'd1) begin
            errors++;
            $display("FAIL drain_to_1: pend3=%0d required 1", pend_of(3));
        end
        evt_with_take(3);
        checks++;
        if (pend_of(3) !== 4'd1 || out_valid[3] !== 1'b1) begin
            errors++;
            $display("FAIL simul_one: pend3=%0d valid3=%b required 1 1", pend_of(3), out_valid[3]);
        end
    endtask

    task automatic test_mid_reset();
        tgl_in = '0;
        tick(1);
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(6);
        checks++;
        if (pend !== '0 || out_valid !== '0 || ovf !== '0) begin
            errors++;
            $display("FAIL mid_reset: pend=%h valid=%b ovf=%b required all 0", pend, out_valid, ovf);
        end
    endtask

    task automatic test_back_to_back();
        tgl_in = ~tgl_in;
        tick(2);
        checks++;
        if (pend !== '0) begin
            errors++;
            $display("FAIL all_early: pend=%h required 0", pend);
        end
        tick(1);
        checks++;
        if (pend !== 16'h1111 || out_valid !== 4'hf) begin
            errors++;
            $display("FAIL all_same_edge: pend=%h valid=%b required 1111 1111", pend, out_valid);
        end
        tick(1);
        for (int i = 0; i < 14; i++) send_evt(0);
        // drop on channel 0 coincides with a clear request: set must win
        tgl_in[0] = ~tgl_in[0];
        tick(2);
        ovf_clr[0] = 1'b1;
        tick(1);
        ovf_clr[0] = 1'b0;
        checks++;
        if (ovf[0] !== 1'b1 || pend_of(0) !== 4'd15) begin
            errors++;
            $display("FAIL set_priority: ovf0=%b pend0=%0d required 1 15", ovf[0], pend_of(0));
        end
        checks++;
        if (ovf[3:1] !== 3'b000) begin
            errors++;
            $display("FAIL ovf_independent: ovf=%b required 0001", ovf);
        end
    endtask

    initial begin
        rst = 1'b1;
        tgl_in = '0;
        out_ready = '0;
        ovf_clr = '0;
        tick(1);
        test_reset();
        test_latency();
        test_accumulate_drain();
        test_overflow();
        test_simultaneous();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
